// File: rtl/alu_pkg.sv
// ALU execute-stage shared definitions.
// Control codes and FSM state encodings.
package alu_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_SLL  = 3'b101;
   localparam logic [2:0] ALU_SLLV = 3'b110;
   localparam logic [2:0] ALU_SRAV = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational add/subtract with signed overflow.
// Subtract is a + ~b + 1 through the same adder.
module alu_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             ovf
);

   logic [WIDTH-1:0] bx;

   assign bx  = sub ? ~b : b;
   assign sum = a + bx + {{(WIDTH-1){1'b0}}, sub};
   assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) &&
                (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub,
// iterative one-bit-per-cycle shifts, valid/ready out.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             busy
);

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;
   logic             sra;

   logic             accept;
   logic             is_shift;
   logic [SHW-1:0]   cnt_ld;
   logic [WIDTH-1:0] sum;
   logic             ovf;

   assign in_ready  = (state == ST_IDLE) ||
                      ((state == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == ST_DONE);
   assign busy      = (state == ST_SHIFT);

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a   (src_a),
      .b   (src_b),
      .sub (alu_ctrl == ALU_SUB),
      .sum (sum),
      .ovf (ovf)
   );

   // Classify the incoming code and pick the shift count source.
   always_comb begin
      is_shift = 1'b0;
      cnt_ld   = src_a[SHW-1:0];
      unique case (1'b1)
         (alu_ctrl == ALU_SLL): begin
            is_shift = 1'b1;
            cnt_ld   = shamt;
         end
         (alu_ctrl == ALU_SLLV),
         (alu_ctrl == ALU_SRAV): is_shift = 1'b1;
         default: ;
      endcase
   end

   // Control FSM, shift datapath and registered result flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         acc      <= '0;
         cnt      <= '0;
         sra      <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  if (is_shift) begin
                     acc   <= src_b;
                     cnt   <= cnt_ld;
                     sra   <= (alu_ctrl == ALU_SRAV);
                     state <= ST_SHIFT;
                  end else begin
                     result   <= sum;
                     zero     <= (sum == '0);
                     overflow <= ovf;
                     state    <= ST_DONE;
                  end
               end else if ((state == ST_DONE) && out_ready) begin
                  state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (cnt != '0) begin
                  // Arithmetic right keeps the MSB, i.e. original sign.
                  acc <= sra ? {acc[WIDTH-1], acc[WIDTH-1:1]}
                             : {acc[WIDTH-2:0], 1'b0};
                  cnt <= cnt - SHW'(1);
               end else begin
                  result   <= acc;
                  zero     <= (acc == '0);
                  overflow <= 1'b0;
                  state    <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
